fft_spectrum_buf: RTL and testbench

- Ping-pong spectrum buffer between the FFT magnitude stream and the HDMI spectrum renderer.
- Captures the first POINTS bins of each FFT output frame, scales each bin to 12 bits, and stores it in the write bank.
- Serves the other (display) bank point-by-point on the renderer's data_req / fft_point_done handshake.
- Banks swap only at a display frame boundary, so a drawn spectrum never tears.

---
 rtl/fft_buf_pkg.sv | 30 +++
 rtl/fft_spec_ram.sv | 30 +++
 rtl/fft_spectrum_buf.sv | 190 +++++++++++++++++++
 tb/tb_fft_spectrum_buf.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_buf_pkg.sv
// Shared types and constants for the FFT spectrum ping-pong buffer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: default bin count, scaled data width, write FSM encoding, log compressor.
package fft_buf_pkg;

   localparam int POINTS_DEF = 256;
   localparam int DATA_W     = 12;

   typedef enum logic [1:0] {
      W_SKIP = 2'd0,   // discarding samples until a frame boundary
      W_FILL = 2'd1,   // capturing bins into the write bank
      W_PEND = 2'd2    // write bank full, waiting for the renderer to swap
   } wstate_t;

   // Log compressor: upper nibble is the leading-one position,
   // lower byte is the 8 bits that follow it (zero-padded for small values).
   function automatic logic [DATA_W-1:0] log_scale(input logic [15:0] mag);
      logic [3:0]  p;
      logic [15:0] sh;
      p = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (mag[i]) p = 4'(i);
      end
      // Normalise so the leading one sits at bit 15; the mantissa is then bits 14:7.
      sh = mag << (4'd15 - p);
      return (mag == 16'd0) ? '0 : {p, sh[14:7]};
   endfunction

endpackage

// File: rtl/fft_spec_ram.sv
// Simple dual-port spectrum RAM: one write port, one registered read port, single clock.
// Latency: 1 cycle from rd_en/rd_addr to rd_data.
// Backpressure: none; accepts one write and one read every cycle.
// Ports: clk; we/wr_addr/wr_data write port; re/rd_addr read request; rd_data registered output.
module fft_spec_ram #(
   parameter int DEPTH = 512,
   parameter int AW    = 9,
   parameter int DW    = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Read data holds between reads so the output stage can be gated by re alone.
   always_ff @(posedge clk) begin
      if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_spectrum_buf.sv
// Ping-pong spectrum buffer: captures POINTS scaled FFT bins per frame, serves the other bank to the renderer.
// Latency: fft_data/fft_point_cnt update 2 cycles after data_req; write side +1 cycle when FFT_LOG_SCALE_EN is defined.
// Backpressure: none on either side; frames that cannot be stored are dropped and counted in frame_drop_cnt.
// Ports: pix_clk, rstn_out (async active-low); fft_valid/fft_last/fft_mag input stream;
//        data_req/fft_point_done renderer handshake; fft_data/fft_point_cnt served point;
//        buf_ready (sticky, first swap done); frame_drop_cnt (saturating).
// Build option: FFT_LOG_SCALE_EN selects the log compressor instead of linear shift-and-saturate.
module fft_spectrum_buf
   import fft_buf_pkg::*;
#(
   parameter int POINTS = POINTS_DEF,
   parameter int MAG_W  = 16,
   parameter int SHIFT  = 4
) (
   input  logic              pix_clk,
   input  logic              rstn_out,
   input  logic              fft_valid,
   input  logic              fft_last,
   input  logic [MAG_W-1:0]  fft_mag,
   input  logic              data_req,
   input  logic              fft_point_done,
   output logic [DATA_W-1:0] fft_data,
   output logic [7:0]        fft_point_cnt,
   output logic              buf_ready,
   output logic [7:0]        frame_drop_cnt
);

   localparam int IW = $clog2(POINTS);

   // ---------------------------------------------------------------
   // Scaling front end: s_* is the sample stream seen by the write FSM
   // ---------------------------------------------------------------
   logic              s_vld;
   logic              s_last;
   logic [DATA_W-1:0] s_dat;
   logic [DATA_W-1:0] scaled;

`ifdef FFT_LOG_SCALE_EN
   assign scaled = log_scale(16'(fft_mag));

   // The compressor's priority encoder is registered to keep it off the RAM write path.
   always_ff @(posedge pix_clk or negedge rstn_out) begin
      if (!rstn_out) begin
         s_vld  <= 1'b0;
         s_last <= 1'b0;
         s_dat  <= '0;
      end else begin
         s_vld  <= fft_valid;
         s_last <= fft_valid & fft_last;
         s_dat  <= scaled;
      end
   end
`else
   logic [MAG_W-1:0] shifted;

   assign shifted = fft_mag >> SHIFT;
   assign scaled  = (shifted > MAG_W'(12'hFFF)) ? 12'hFFF : shifted[DATA_W-1:0];
   assign s_vld   = fft_valid;
   assign s_last  = fft_last;
   assign s_dat   = scaled;
`endif

   // ---------------------------------------------------------------
   // Write FSM and bank swap
   // ---------------------------------------------------------------
   wstate_t       wstate;
   logic [IW-1:0] wr_idx;
   logic          wr_bank;
   logic          pend;       // bank filled mid-frame; go to W_PEND once the frame tail passes
   logic          in_frame;   // a new frame is streaming while we wait in W_PEND
   logic          in_frame_nxt;
   logic          swap;
   logic          drop_evt;
   logic          wr_en;
   logic          at_top;

   assign at_top       = (wr_idx == IW'(POINTS - 1));
   assign swap         = fft_point_done && (wstate == W_PEND);
   assign wr_en        = s_vld && (wstate == W_FILL);
   // Include the current sample so a swap on a frame's first beat skips that frame.
   assign in_frame_nxt = s_vld ? !s_last : in_frame;
   assign drop_evt     = s_vld && s_last &&
                         (((wstate == W_FILL) && !at_top) || (wstate == W_PEND));

   always_ff @(posedge pix_clk or negedge rstn_out) begin
      if (!rstn_out) begin
         wstate         <= W_SKIP;
         wr_idx         <= '0;
         wr_bank        <= 1'b0;
         pend           <= 1'b0;
         in_frame       <= 1'b0;
         buf_ready      <= 1'b0;
         frame_drop_cnt <= '0;
      end else begin
         if (drop_evt && (frame_drop_cnt != 8'hFF)) begin
            frame_drop_cnt <= frame_drop_cnt + 8'd1;
         end
         case (wstate)
            W_SKIP: begin
               if (s_vld && s_last) begin
                  wr_idx   <= '0;
                  in_frame <= 1'b0;
                  pend     <= 1'b0;
                  wstate   <= pend ? W_PEND : W_FILL;
               end
            end
            W_FILL: begin
               if (s_vld) begin
                  if (at_top) begin
                     wr_idx <= '0;
                     if (s_last) begin
                        in_frame <= 1'b0;
                        wstate   <= W_PEND;
                     end else begin
                        // Long frame: bank is full but the tail must drain first.
                        pend   <= 1'b1;
                        wstate <= W_SKIP;
                     end
                  end else if (s_last) begin
                     wr_idx <= '0;   // short frame: restart capture at bin 0
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            W_PEND: begin
               in_frame <= in_frame_nxt;
               if (swap) begin
                  wr_bank   <= ~wr_bank;
                  buf_ready <= 1'b1;
                  wr_idx    <= '0;
                  wstate    <= in_frame_nxt ? W_SKIP : W_FILL;
               end
            end
            default: wstate <= W_SKIP;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Read path: done/swap takes effect before a same-cycle request
   // ---------------------------------------------------------------
   logic              rd_bank;
   logic [IW-1:0]     rd_idx;
   logic [IW-1:0]     rd_idx_eff;
   logic              req_d;
   logic [IW-1:0]     idx_d;
   logic [DATA_W-1:0] ram_q;

   // On a swap cycle the new display bank is the current write bank.
   assign rd_bank    = swap ? wr_bank : ~wr_bank;
   assign rd_idx_eff = fft_point_done ? '0 : rd_idx;

   always_ff @(posedge pix_clk or negedge rstn_out) begin
      if (!rstn_out) begin
         rd_idx        <= '0;
         req_d         <= 1'b0;
         idx_d         <= '0;
         fft_data      <= '0;
         fft_point_cnt <= '0;
      end else begin
         if (data_req) begin
            rd_idx <= rd_idx_eff + 1'b1;   // POINTS is a power of 2, so this wraps
            idx_d  <= rd_idx_eff;
         end else if (fft_point_done) begin
            rd_idx <= '0;
         end
         req_d <= data_req;
         if (req_d) begin
            fft_point_cnt <= 8'(idx_d);
            fft_data      <= buf_ready ? ram_q : '0;
         end
      end
   end

   fft_spec_ram #(
      .DEPTH (2 * POINTS),
      .AW    (IW + 1),
      .DW    (DATA_W)
   ) u_ram (
      .clk     (pix_clk),
      .we      (wr_en),
      .wr_addr ({wr_bank, wr_idx}),
      .wr_data (s_dat),
      .re      (data_req),
      .rd_addr ({rd_bank, rd_idx_eff}),
      .rd_data (ram_q)
   );

endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Scoreboard bench for fft_spectrum_buf: drives FFT frames and renderer requests,
// queues the expected served point per request and compares 2 cycles later.
// Build option: FFT_LOG_SCALE_EN switches the expected scaling to the log compressor.
module tb_fft_spectrum_buf;

   logic        pix_clk = 1'b0;
   logic        rstn_out;
   logic        fft_valid;
   logic        fft_last;
   logic [15:0] fft_mag;
   logic        data_req;
   logic        fft_point_done;
   logic [11:0] fft_data;
   logic [7:0]  fft_point_cnt;
   logic        buf_ready;
   logic [7:0]  frame_drop_cnt;

   fft_spectrum_buf #(.POINTS(256), .MAG_W(16), .SHIFT(4)) dut (
      .pix_clk        (pix_clk),
      .rstn_out       (rstn_out),
      .fft_valid      (fft_valid),
      .fft_last       (fft_last),
      .fft_mag        (fft_mag),
      .data_req       (data_req),
      .fft_point_done (fft_point_done),
      .fft_data       (fft_data),
      .fft_point_cnt  (fft_point_cnt),
      .buf_ready      (buf_ready),
      .frame_drop_cnt (frame_drop_cnt)
   );

   always #5 pix_clk = ~pix_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame content: bin k of frame 'base' carries 16*(k+base); base 999 has special leading bins.
   function automatic logic [15:0] mag_of(input int base, input int k);
      if (base == 999 && k == 0) return 16'h0180;
      if (base == 999 && k == 1) return 16'h0001;
      if (base == 999 && k == 2) return 16'hFFFF;
      if (base == 999) return 16'(16 * k);
      return 16'(16 * ((k + base) % 4096));
   endfunction

   function automatic logic [11:0] exp_scale(input logic [15:0] mag);
`ifdef FFT_LOG_SCALE_EN
      int p;
      int frac;
      if (mag == 16'd0) return 12'h000;
      p = 0;
      for (int b = 0; b < 16; b++) if (mag[b]) p = b;
      frac = ((int'(mag) - (1 << p)) * 256) >> p;
      return 12'((p << 8) | (frac & 255));
`else
      int v;
      v = int'(mag) >> 4;
      return (v > 4095) ? 12'hFFF : 12'(v);
`endif
   endfunction

   typedef struct packed {
      logic [7:0]  cnt;
      logic [11:0] dat;
   } exp_t;

   exp_t exp_q[$];

   // Reference: which frame is on display, which one is waiting, and the read pointer.
   int disp_base = -1;
   int pend_base = -1;
   bit ready     = 1'b0;
   int model_idx = 0;

   task automatic push_exp();
      exp_t e;
      e.cnt = 8'(model_idx);
      e.dat = ready ? exp_scale(mag_of(disp_base, model_idx)) : 12'h000;
      exp_q.push_back(e);
      model_idx = (model_idx + 1) % 256;
   endtask

   // Request pipeline tracker: compare the served point exactly 2 cycles after its request.
   logic [1:0] req_pipe = 2'b00;
   always @(posedge pix_clk) req_pipe <= {req_pipe[0], data_req};

   always @(negedge pix_clk) begin
      if (req_pipe[1]) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("pt_cnt", 32'(fft_point_cnt), 32'(e.cnt));
            check_eq("pt_dat", 32'(fft_data), 32'(e.dat));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge pix_clk);
   endtask

   task automatic send_frame(input int first, input int stop, input int base, input bit with_last);
      for (int k = first; k < stop; k++) begin
         fft_valid = 1'b1;
         fft_mag   = mag_of(base, k);
         fft_last  = with_last && (k == stop - 1);
         @(negedge pix_clk);
      end
      fft_valid = 1'b0;
      fft_last  = 1'b0;
      idle(3);
   endtask

   task automatic req(input int n);
      for (int i = 0; i < n; i++) begin
         data_req = 1'b1;
         push_exp();
         @(negedge pix_clk);
      end
      data_req = 1'b0;
      idle(3);
   endtask

   task automatic done(input bit do_swap);
      fft_point_done = 1'b1;
      model_idx = 0;
      if (do_swap) begin
         ready     = 1'b1;
         disp_base = pend_base;
      end
      @(negedge pix_clk);
      fft_point_done = 1'b0;
      idle(1);
   endtask

   task automatic done_req(input bit do_swap);
      fft_point_done = 1'b1;
      data_req       = 1'b1;
      model_idx      = 0;
      if (do_swap) begin
         ready     = 1'b1;
         disp_base = pend_base;
      end
      push_exp();
      @(negedge pix_clk);
      fft_point_done = 1'b0;
      data_req       = 1'b0;
      idle(3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_data"},  32'(fft_data), 32'd0);
      check_eq({tag, "_cnt"},   32'(fft_point_cnt), 32'd0);
      check_eq({tag, "_ready"}, 32'(buf_ready), 32'd0);
      check_eq({tag, "_drop"},  32'(frame_drop_cnt), 32'd0);
   endtask

   initial begin
      rstn_out       = 1'b0;
      fft_valid      = 1'b0;
      fft_last       = 1'b0;
      fft_mag        = '0;
      data_req       = 1'b0;
      fft_point_done = 1'b0;
      idle(3);
      check_reset_outputs("rst");
      rstn_out = 1'b1;
      idle(2);

      // Requests before any swap: index advances, data forced to zero.
      req(3);

      // First frame after reset is skipped; done does not swap.
      send_frame(0, 256, 0, 1'b1);
      check_eq("drop_after_first", 32'(frame_drop_cnt), 32'd0);
      done(1'b0);
      check_eq("ready_no_swap", 32'(buf_ready), 32'd0);

      // Second identical frame is captured and swapped in; read the whole spectrum back-to-back.
      pend_base = 0;
      send_frame(0, 256, 0, 1'b1);
      done(1'b1);
      check_eq("ready_after_swap", 32'(buf_ready), 32'd1);
      req(256);

      // Three frames without a swap: first is kept, the next two are dropped.
      pend_base = 1;
      send_frame(0, 256, 1, 1'b1);
      send_frame(0, 256, 2, 1'b1);
      send_frame(0, 256, 3, 1'b1);
      check_eq("drop_three_frames", 32'(frame_drop_cnt), 32'd2);
      done(1'b1);
      req(4);

      // Short frame is dropped; the following full frame starts at bin 0.
      send_frame(0, 100, 5, 1'b1);
      check_eq("drop_short_frame", 32'(frame_drop_cnt), 32'd3);
      pend_base = 6;
      send_frame(0, 256, 6, 1'b1);
      done(1'b1);
      req(256);

      // Simultaneous done and request serves index 0 of the new bank, then index 1.
      pend_base = 7;
      send_frame(0, 256, 7, 1'b1);
      req(2);
      done_req(1'b1);
      req(1);

      // Scaling corner values in the first three bins.
      pend_base = 999;
      send_frame(0, 256, 999, 1'b1);
      done(1'b1);
      req(3);

      // Reset mid-frame: outputs clear and the rest of that frame is skipped.
      send_frame(0, 50, 10, 1'b0);
      rstn_out = 1'b0;
      ready = 1'b0;
      disp_base = -1;
      model_idx = 0;
      idle(2);
      check_reset_outputs("midrst");
      rstn_out = 1'b1;
      idle(1);
      send_frame(50, 256, 10, 1'b1);
      pend_base = 11;
      send_frame(0, 256, 11, 1'b1);
      req(2);
      check_eq("drop_after_midrst", 32'(frame_drop_cnt), 32'd0);
      done(1'b1);
      req(4);

      // Saturation: 260 short frames in W_FILL must stop the counter at 255.
      for (int f = 0; f < 260; f++) begin
         fft_valid = 1'b1;
         fft_last  = 1'b0;
         fft_mag   = 16'h0010;
         @(negedge pix_clk);
         fft_last  = 1'b1;
         @(negedge pix_clk);
      end
      fft_valid = 1'b0;
      fft_last  = 1'b0;
      idle(3);
      check_eq("drop_saturate", 32'(frame_drop_cnt), 32'd255);

      idle(4);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
